// File: rtl/pll_lock_ctrl_if.sv
// Signal bundle between the PLL lock controller and its environment.
// The slave side is the controller; the master side models the PLL and the reset consumers.
interface pll_lock_ctrl_if #(
    parameter int unsigned STAT_W = 8
);
    logic              pll_locked;
    logic              force_relock;
    logic              pll_rst;
    logic              sys_reset;
    logic              ready;
    logic [STAT_W-1:0] relock_count;

    modport master (
        output pll_locked,
        output force_relock,
        input  pll_rst,
        input  sys_reset,
        input  ready,
        input  relock_count
    );

    modport slave (
        input  pll_locked,
        input  force_relock,
        output pll_rst,
        output sys_reset,
        output ready,
        output relock_count
    );
endinterface

// File: rtl/pll_lock_ctrl.sv
// PLL reset/relock sequencer: pulses pll_rst, waits for stable lock, and holds
// sys_reset until lock has persisted; all outputs are registered in refclk.
module pll_lock_ctrl #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_W               = 17,
    parameter int unsigned STAT_W              = 8
) (
    input logic            refclk,
    input logic            rst,
    pll_lock_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        PLL_RESET = 2'b00,
        WAIT_LOCK = 2'b01,
        STABLE    = 2'b10,
        RUN       = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              sync1;
    logic              lk;
    logic              relock_evt;
    logic              pll_rst_q;
    logic              sys_reset_q;
    logic              ready_q;
    logic              pll_rst_d;
    logic              sys_reset_d;
    logic              ready_d;
    logic [STAT_W-1:0] relock_q;
    logic [STAT_W-1:0] relock_d;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync1 <= bus.pll_locked;
            lk    <= sync1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= PLL_RESET;
            cnt         <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            relock_q    <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            pll_rst_q   <= pll_rst_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
            relock_q    <= relock_d;
        end
    end

    // force_relock outranks every other transition but is a no-op in PLL_RESET.
    always_comb begin
        state_next = state;
        relock_evt = 1'b0;
        if (bus.force_relock && (state != PLL_RESET)) begin
            state_next = PLL_RESET;
            relock_evt = 1'b1;
        end else begin
            case (state)
                PLL_RESET: begin
                    if (cnt == RST_LAST) begin
                        state_next = WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state_next = STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state_next = PLL_RESET;
                        relock_evt = 1'b1;
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        state_next = WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state_next = PLL_RESET;
                        relock_evt = 1'b1;
                    end
                end
                default: begin
                    state_next = PLL_RESET;
                end
            endcase
        end

        cnt_next = (state_next != state) ? '0 : cnt + CNT_W'(1);
        relock_d = (relock_evt && (relock_q != '1)) ? relock_q + STAT_W'(1) : relock_q;
    end

    // Outputs decoded from the next state so they move on the same edge as the state.
    always_comb begin
        pll_rst_d   = 1'b1;
        sys_reset_d = 1'b1;
        ready_d     = 1'b0;
        case (state_next)
            WAIT_LOCK, STABLE: begin
                pll_rst_d = 1'b0;
            end
            RUN: begin
                pll_rst_d   = 1'b0;
                sys_reset_d = 1'b0;
                ready_d     = 1'b1;
            end
            default: begin
                pll_rst_d   = 1'b1;
                sys_reset_d = 1'b1;
                ready_d     = 1'b0;
            end
        endcase
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.sys_reset    = sys_reset_q;
    assign bus.ready        = ready_q;
    assign bus.relock_count = relock_q;
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl: segment tables of {inputs, cycles, expected outputs}
// plus a timeout/saturation loop.
module tb_pll_lock_ctrl;
    logic refclk = 1'b0;
    logic rst    = 1'b1;

    pll_lock_ctrl_if #(.STAT_W(2)) bus ();

    pll_lock_ctrl #(
        .RST_PULSE_CYCLES(4),
        .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(32),
        .CNT_W(6),
        .STAT_W(2)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .bus(bus)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        int unsigned test;
        logic        rst_in;
        logic        locked;
        logic        force_in;
        int unsigned n;
        logic        e_pll_rst;
        logic        e_sys_reset;
        logic        e_ready;
        logic [1:0]  e_count;
    } seg_t;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    seg_t        tbl_a[$];
    seg_t        tbl_b[$];

    function automatic seg_t mk(int unsigned t, int unsigned r, int unsigned l, int unsigned f,
                                int unsigned n, int unsigned pr, int unsigned sr,
                                int unsigned rd, int unsigned c);
        seg_t s;
        s.test        = t;
        s.rst_in      = (r != 0);
        s.locked      = (l != 0);
        s.force_in    = (f != 0);
        s.n           = n;
        s.e_pll_rst   = (pr != 0);
        s.e_sys_reset = (sr != 0);
        s.e_ready     = (rd != 0);
        s.e_count     = 2'(c);
        return s;
    endfunction

    task automatic check_out(input int unsigned test, input int unsigned idx, input logic e_pr,
                             input logic e_sr, input logic e_rd, input logic [1:0] e_cnt);
        checks++;
        if ({bus.pll_rst, bus.sys_reset, bus.ready, bus.relock_count} !== {e_pr, e_sr, e_rd, e_cnt}) begin
            errors++;
            $display("FAIL T%0d seg%0d cycle %0d: pll_rst/sys_reset/ready/count got %b/%b/%b/%0d want %b/%b/%b/%0d",
                     test, idx, cyc, bus.pll_rst, bus.sys_reset, bus.ready, bus.relock_count,
                     e_pr, e_sr, e_rd, e_cnt);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    // Drive the segment inputs for n cycles, checking the outputs of each cycle before its edge.
    task automatic apply_seg(input seg_t s, input int unsigned idx);
        for (int unsigned i = 0; i < s.n; i++) begin
            rst              = s.rst_in;
            bus.pll_locked   = s.locked;
            bus.force_relock = s.force_in;
            check_out(s.test, idx, s.e_pll_rst, s.e_sys_reset, s.e_ready, s.e_count);
            step();
            if (s.rst_in) cyc = 0;
        end
        rst              = 1'b0;
        bus.force_relock = 1'b0;
    endtask

    initial begin
        // test rst lk frc n   pll_rst sys_reset ready count
        tbl_a.push_back(mk(1, 0, 0, 0, 4,  1, 1, 0, 0));
        tbl_a.push_back(mk(1, 0, 0, 0, 6,  0, 1, 0, 0));
        tbl_a.push_back(mk(1, 0, 1, 0, 11, 0, 1, 0, 0));
        tbl_a.push_back(mk(1, 0, 1, 0, 5,  0, 0, 1, 0));
        tbl_a.push_back(mk(4, 0, 0, 0, 3,  0, 0, 1, 0));
        tbl_a.push_back(mk(4, 0, 0, 0, 4,  1, 1, 0, 1));
        tbl_a.push_back(mk(4, 0, 1, 0, 11, 0, 1, 0, 1));
        tbl_a.push_back(mk(4, 0, 1, 0, 3,  0, 0, 1, 1));
        tbl_a.push_back(mk(5, 0, 1, 1, 1,  0, 0, 1, 1));
        tbl_a.push_back(mk(5, 0, 1, 0, 1,  1, 1, 0, 2));
        tbl_a.push_back(mk(5, 0, 1, 1, 1,  1, 1, 0, 2));
        tbl_a.push_back(mk(5, 0, 1, 0, 2,  1, 1, 0, 2));
        tbl_a.push_back(mk(5, 0, 1, 0, 9,  0, 1, 0, 2));
        tbl_a.push_back(mk(5, 0, 1, 0, 2,  0, 0, 1, 2));
        tbl_a.push_back(mk(3, 0, 1, 1, 1,  0, 0, 1, 2));
        tbl_a.push_back(mk(3, 0, 1, 0, 4,  1, 1, 0, 3));
        tbl_a.push_back(mk(3, 0, 1, 0, 5,  0, 1, 0, 3));
        tbl_a.push_back(mk(3, 0, 0, 0, 1,  0, 1, 0, 3));
        tbl_a.push_back(mk(3, 0, 1, 0, 11, 0, 1, 0, 3));
        tbl_a.push_back(mk(3, 0, 1, 0, 2,  0, 0, 1, 3));
        tbl_a.push_back(mk(2, 1, 0, 0, 1,  0, 0, 1, 3));

        tbl_b.push_back(mk(6, 0, 1, 0, 4,  1, 1, 0, 3));
        tbl_b.push_back(mk(6, 0, 1, 0, 3,  0, 1, 0, 3));
        tbl_b.push_back(mk(6, 1, 1, 0, 1,  0, 1, 0, 3));
        tbl_b.push_back(mk(6, 0, 1, 0, 4,  1, 1, 0, 0));
        tbl_b.push_back(mk(6, 0, 1, 0, 9,  0, 1, 0, 0));
        tbl_b.push_back(mk(6, 0, 1, 0, 3,  0, 0, 1, 0));

        bus.pll_locked   = 1'b0;
        bus.force_relock = 1'b0;
        rst              = 1'b1;
        repeat (3) @(posedge refclk);
        #1;
        check_out(0, 0, 1'b1, 1'b1, 1'b0, 2'd0);
        rst = 1'b0;
        cyc = 0;

        foreach (tbl_a[i]) apply_seg(tbl_a[i], i);

        // Lock never arrives: 4-cycle pulse then 32-cycle wait per attempt, count saturating at 3.
        for (int unsigned k = 0; k < 5; k++) begin
            int unsigned exp_cnt;
            exp_cnt = (k > 3) ? 3 : k;
            apply_seg(mk(2, 0, 0, 0, 4,  1, 1, 0, exp_cnt), 100 + 2 * k);
            apply_seg(mk(2, 0, 0, 0, 32, 0, 1, 0, exp_cnt), 101 + 2 * k);
        end

        foreach (tbl_b[i]) apply_seg(tbl_b[i], i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
